// File: rtl/spi_slave_ctrl.sv
// SPI slave front end: deserialises MOSI frames into RAM commands and returns read bytes on MISO.
// Latency: rx_valid rises on the 11th clk edge after SS_n is first seen low; MISO starts the cycle after tx_valid.
// Backpressure: none; SS_n high aborts any frame or MISO byte in progress, and tx_valid is awaited without timeout.
//
// Ports:
//   clk, rst_n        system/SPI bit clock (rising edge), asynchronous active-low reset
//   SS_n, MOSI, MISO  SPI slave select (frame boundary), serial in/out, MSB first
//   rx_data, rx_valid assembled {opcode[1:0], payload} command and its one-cycle strobe
//   tx_data, tx_valid read byte returned by the RAM and its valid
module spi_slave_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [DATA_WIDTH+1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid
);

  localparam int FW = DATA_WIDTH + 2;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  // Holds frame bits 9..1; bit 0 is taken straight from MOSI on the final edge.
  logic [FW-2:0]         shift_q, shift_d;
  logic [FW-1:0]         rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rd_addr_seen_q, rd_addr_seen_d;
  // Set once the strobe for the current frame has been issued; later MOSI bits are ignored.
  logic                  frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [CW-1:0]         tx_left_q, tx_left_d;
  logic                  tx_busy_q, tx_busy_d;
  // Only the first tx_valid of a frame is accepted.
  logic                  tx_latched_q, tx_latched_d;
  logic                  miso_q, miso_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    frame_done_d   = frame_done_q;
    tx_shift_d     = tx_shift_q;
    tx_left_d      = tx_left_q;
    tx_busy_d      = tx_busy_q;
    tx_latched_d   = tx_latched_q;
    miso_d         = miso_q;

    if (SS_n) begin
      // Frame boundary: drop partial frame and any MISO byte; rd_addr_seen survives.
      state_d      = IDLE;
      cnt_d        = '0;
      shift_d      = '0;
      frame_done_d = 1'b0;
      tx_left_d    = '0;
      tx_busy_d    = 1'b0;
      tx_latched_d = 1'b0;
      miso_d       = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = CHK_CMD;
          cnt_d        = '0;
          frame_done_d = 1'b0;
          miso_d       = 1'b0;
        end
        CHK_CMD: begin
          shift_d = {{(FW-2){1'b0}}, MOSI};
          cnt_d   = '0;
          if (!MOSI)               state_d = WRITE;
          else if (rd_addr_seen_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (!frame_done_q) begin
            shift_d = {shift_q[FW-3:0], MOSI};
            if (cnt_q == CW'(DATA_WIDTH)) begin
              rx_data_d    = {shift_q, MOSI};
              rx_valid_d   = 1'b1;
              frame_done_d = 1'b1;
              if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (state_q == READ_DATA) begin
            if (tx_busy_q) begin
              if (tx_left_q != '0) begin
                miso_d     = tx_shift_q[DATA_WIDTH-1];
                tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                tx_left_d  = tx_left_q - 1'b1;
              end else begin
                // Last bit has been on the line for a full cycle.
                miso_d         = 1'b0;
                tx_busy_d      = 1'b0;
                rd_addr_seen_d = 1'b0;
              end
            end else if (tx_valid && !tx_latched_q) begin
              // MSB goes out immediately; the rest is pre-shifted.
              miso_d       = tx_data[DATA_WIDTH-1];
              tx_shift_d   = {tx_data[DATA_WIDTH-2:0], 1'b0};
              tx_left_d    = CW'(DATA_WIDTH - 1);
              tx_busy_d    = 1'b1;
              tx_latched_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      frame_done_q   <= 1'b0;
      tx_shift_q     <= '0;
      tx_left_q      <= '0;
      tx_busy_q      <= 1'b0;
      tx_latched_q   <= 1'b0;
      miso_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      frame_done_q   <= frame_done_d;
      tx_shift_q     <= tx_shift_d;
      tx_left_q      <= tx_left_d;
      tx_busy_q      <= tx_busy_d;
      tx_latched_q   <= tx_latched_d;
      miso_q         <= miso_d;
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl with a small command-RAM model.
// Latency: frames are clocked in one bit per cycle; strobes are expected on edge 11 after SS_n low.
// Backpressure: the RAM model answers a strobe with tx_valid the following cycle when a vector asks for it.
module tb_spi_slave_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  always #5 clk = ~clk;

  spi_slave_ctrl #(.DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  typedef struct {
    logic [9:0] frame;
    int         nbits;     // frame bits driven (from bit 9 down)
    int         hold;      // extra cycles with SS_n low, MOSI=1
    int         tx_len;    // cycles of tx_valid after the strobe (0 = none)
    bit         exp_valid;
    logic [9:0] exp_data;
    int         miso_mode; // 0: MISO must stay 0, 1: full byte check, 2: only idle after SS_n
    logic [7:0] exp_miso;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] mem [256];
  logic [7:0] wr_addr;
  logic [7:0] rd_addr;
  logic [9:0] last_rx;
  vec_t       vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input int id);
    int         vcount = 0;
    int         vedge = 0;
    logic [9:0] vdata = '0;
    logic [7:0] mbyte = '0;
    logic       mtail = 1'b0;
    bit         stray = 1'b0;
    int         tx_left = 0;
    int         total;
    total = v.nbits + v.hold + 1;
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'b0;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      if (tx_valid) begin
        if (tx_left == 0) tx_valid = 1'b0;
        else tx_left--;
      end
      if (MISO === 1'b1) stray = 1'b1;
      if (k >= 12 && k <= 19) mbyte[19-k] = MISO;
      if (k == 20) mtail = MISO;
      if (rx_valid === 1'b1) begin
        vcount++;
        vedge = k;
        vdata = rx_data;
        case (rx_data[9:8])
          2'b00: wr_addr = rx_data[7:0];
          2'b01: mem[wr_addr] = rx_data[7:0];
          2'b10: rd_addr = rx_data[7:0];
          default: ;
        endcase
        if (v.tx_len > 0) begin
          tx_valid = 1'b1;
          tx_data  = mem[rd_addr];
          tx_left  = v.tx_len - 1;
        end
      end
      if (k <= v.nbits) MOSI = v.frame[10-k];
      else if (k < total) MOSI = 1'b1;
      else begin
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
      end
    end
    @(negedge clk);
    check($sformatf("v%0d_miso_after_ss", id), MISO, 0);
    check($sformatf("v%0d_strobe_count", id), vcount, v.exp_valid ? 1 : 0);
    if (v.exp_valid) begin
      check($sformatf("v%0d_strobe_edge", id), vedge, 11);
      check($sformatf("v%0d_rx_data", id), vdata, v.exp_data);
      last_rx = v.exp_data;
    end
    check($sformatf("v%0d_rx_hold", id), rx_data, last_rx);
    if (v.miso_mode == 0) begin
      check($sformatf("v%0d_miso_quiet", id), stray, 0);
    end else if (v.miso_mode == 1) begin
      check($sformatf("v%0d_miso_byte", id), mbyte, v.exp_miso);
      check($sformatf("v%0d_miso_tail", id), mtail, 0);
    end
  endtask

  initial begin
    vec_t       rv;
    logic [9:0] part;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    wr_addr  = 8'h00;
    rd_addr  = 8'h00;
    last_rx  = 10'h000;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rst_n    = 1'b1;

    //          frame    nb  hold tx  vld  data     mode miso
    vecs[0] = '{10'h03C, 10, 2,   0,  1'b1, 10'h03C, 0,   8'h00}; // write address
    vecs[1] = '{10'h1A5, 10, 2,   0,  1'b1, 10'h1A5, 0,   8'h00}; // write data
    vecs[2] = '{10'h23C, 10, 2,   0,  1'b1, 10'h23C, 0,   8'h00}; // read address
    vecs[3] = '{10'h300, 10, 12,  1,  1'b1, 10'h300, 1,   8'hA5}; // read data
    vecs[4] = '{10'h23C, 10, 12,  1,  1'b1, 10'h23C, 0,   8'h00}; // back to READ_ADD
    vecs[5] = '{10'h3FF, 10, 4,   1,  1'b1, 10'h3FF, 2,   8'h00}; // MISO byte aborted
    vecs[6] = '{10'h300, 10, 12,  3,  1'b1, 10'h300, 1,   8'hA5}; // still READ_DATA, extra tx_valid
    vecs[7] = '{10'h1FF, 5,  0,   0,  1'b0, 10'h000, 0,   8'h00}; // aborted frame
    vecs[8] = '{10'h010, 10, 2,   0,  1'b1, 10'h010, 0,   8'h00}; // frame after abort
    vecs[9] = '{10'h055, 10, 6,   0,  1'b1, 10'h055, 0,   8'h00}; // overlong frame

    #2 rst_n = 1'b0;
    #1;
    check("reset_miso", MISO, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_frame(vecs[i], i);

    // Reset in the middle of a write frame.
    part = 10'h1A5;
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      MOSI = part[10-k];
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_miso", MISO, 0);
    check("midreset_rx_valid", rx_valid, 0);
    check("midreset_rx_data", rx_data, 0);
    SS_n    = 1'b1;
    MOSI    = 1'b0;
    last_rx = 10'h000;
    @(negedge clk);
    rst_n = 1'b1;

    rv = '{10'h03C, 10, 2, 0, 1'b1, 10'h03C, 0, 8'h00};
    run_frame(rv, 10);
    // Reset cleared rd_addr_seen, so a read opcode is an address frame and tx_valid is ignored.
    rv = '{10'h300, 10, 12, 1, 1'b1, 10'h300, 0, 8'h00};
    run_frame(rv, 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
- SPI slave front end that sequences the single-port command RAM.
- Deserialises MOSI frames into 10-bit RAM commands: bits [9:8] are the opcode, bits [7:0] are the payload.
- Pulses rx_valid once per completed frame.
- For read-data frames, waits for the RAM's tx_valid, captures the read byte and shifts it out on MISO MSB-first.
- The SPI bit clock is the system clock clk; the master holds MOSI stable across the rising edge.

Parameters:
- DATA_WIDTH, 8: RAM data/address byte width. Frame width is DATA_WIDTH+2.

Ports:
- clk  in  1  system/SPI clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- SS_n  in  1  slave select, active low; frame boundary.
- MOSI  in  1  serial data from master, MSB first.
- MISO  out  1  serial read data to master, MSB first.
- rx_data  out  DATA_WIDTH+2  assembled command to RAM din.
- rx_valid  out  1  one-cycle strobe, rx_data valid.
- tx_data  in  DATA_WIDTH  read byte from RAM dout.
- tx_valid  in  1  RAM read data valid.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; MISO=0, rx_data=0, rx_valid=0.
  - bit counter=0; rd_addr_seen=0; tx shift reg=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- SS_n=1 sampled in any state: next state IDLE.
  - Partial shift contents discarded; no rx_valid; any MISO shift in progress aborted; MISO=0.
  - rd_addr_seen is unchanged.
- IDLE: SS_n=0 -> CHK_CMD. MISO=0.
- CHK_CMD: samples MOSI as frame bit 9 into shift_reg[9].
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA: sample bits 8..0 on 9 consecutive edges; counter counts 0..8.
  - On the edge that samples bit 0, rx_data is loaded with the full 10-bit frame and rx_valid=1.
  - rx_valid is 1 in the following cycle only; a single strobe per frame.
  - Bits [9:8] are forwarded unmodified; the RAM decodes the opcode.
- WRITE and READ_ADD after the strobe:
  - Remain in state, ignoring MOSI, until SS_n=1.
  - READ_ADD sets rd_addr_seen=1 on the strobe edge.
- READ_DATA after the strobe:
  - Wait for tx_valid=1 with no timeout. The first tx_valid edge latches tx_data into the tx shift reg; later tx_valid cycles are ignored.
  - Starting the cycle after the latch, MISO presents bit 7, 6, ... 0 on 8 consecutive cycles, updated each rising edge.
  - Then MISO=0 and rd_addr_seen cleared.
  - Remain in READ_DATA until SS_n=1.
- Latency: the rx_valid rising edge is 11 clk edges after the first edge with SS_n=0 (1 IDLE + 1 CHK_CMD + 9 data bits).
- Frame longer than 10 bits: extra MOSI bits ignored; no second strobe.
- SS_n deasserted before the MISO byte completes:
  - Transfer abandoned; MISO=0.
  - rd_addr_seen remains 1, so the next read-opcode frame is again treated as READ_DATA.
- rx_data holds its last value between strobes.
- rd_addr_seen toggles only on completed READ_ADD strobes and completed READ_DATA byte transmissions.

Test Plan:
- Reset mid-frame: assert rst_n=0 after 5 MOSI bits of a write frame -> immediately MISO=0, rx_valid=0, rx_data=0. The next complete frame 00_0x3C is processed normally.
- Write address then data: frames 00_0x3C then 01_0xA5, SS_n high between -> two single-cycle rx_valid strobes with rx_data=0x03C then 0x1A5, each 11 edges after SS_n low.
- Read address: frame 10_0x3C -> rx_valid with rx_data=0x23C; rd_addr_seen=1; MISO stays 0.
- Read data: after preload RAM[0x3C]=0xA5, send frame 11_0x00 -> rx_data=0x300. Model tx_valid one cycle after rx_valid. MISO then emits 1,0,1,0,0,1,0,1 on 8 consecutive cycles, then 0. The next read-opcode frame goes to READ_ADD.
- Abort: SS_n=1 after 4 data bits of frame 01_0xFF -> no rx_valid, state IDLE next cycle. The following full frame 00_0x10 -> rx_valid with rx_data=0x010.
- Overlong frame: hold SS_n low 16 bits with frame 00_0x55 followed by 1s -> exactly one rx_valid, rx_data=0x055.
